// File: rtl/countdown_timer.sv
// Programmable down-counting timer with prescaler,
// one-cycle done pulse, sticky irq and optional auto-reload.
module countdown_timer #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             start,
  input  logic             stop,
  input  logic             autoReload,
  input  logic             tick,
  input  logic             clearIrq,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done,
  output logic             irq
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX =
    PW'(PRESCALE - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] rld;
  logic [WIDTH-1:0] rld_n;
  logic [PW-1:0]    pre;
  logic [PW-1:0]    pre_n;
  logic             done_n;
  logic             irq_n;
  logic             is_run;
  logic             can_reload;

  assign is_run     = (state == RUN);
  assign can_reload = autoReload &&
                      (rld != '0);

  // running is a pure decode of the state register
  assign running = is_run;

  // State, count, reload, prescaler and flag registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      rld   <= '0;
      pre   <= '0;
      done  <= 1'b0;
      irq   <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      rld   <= rld_n;
      pre   <= pre_n;
      done  <= done_n;
      irq   <= irq_n;
    end
  end

  // Next state: load > stop > start > decrement event
  always_comb begin
    state_n = state;
    count_n = count;
    rld_n   = rld;
    pre_n   = pre;
    done_n  = 1'b0;
    irq_n   = irq;
    if (clearIrq) begin
      irq_n = 1'b0;
    end
    unique case (1'b1)
      load: begin
        count_n = loadValue;
        rld_n   = loadValue;
        pre_n   = '0;
      end
      stop: begin
        if (is_run) begin
          state_n = IDLE;
        end
      end
      start: begin
        if (!is_run && count != '0) begin
          state_n = RUN;
          pre_n   = '0;
        end
      end
      default: begin
        if (is_run && tick) begin
          if (pre == PMAX) begin
            pre_n = '0;
            if (count > WIDTH'(1)) begin
              count_n = count - WIDTH'(1);
            end else if (count == WIDTH'(1)) begin
              // Expiry: set beats a same-cycle clear
              done_n = 1'b1;
              irq_n  = 1'b1;
              if (can_reload) begin
                count_n = rld;
              end else begin
                count_n = '0;
                state_n = IDLE;
              end
            end
          end else begin
            pre_n = pre + PW'(1);
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer,
// PRESCALE=1 and PRESCALE=4 instances on shared inputs.
module tb_countdown_timer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] loadValue = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        autoReload = 1'b0;
  logic        tick = 1'b0;
  logic        clearIrq = 1'b0;

  logic [15:0] c1, c4;
  logic        r1, r4, d1, d4, i1, i4;

  logic arl = 1'b0;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [15:0] c;
    logic        r;
    logic        d;
    logic        i;
  } exp_t;

  exp_t q[$];

  typedef struct {
    logic        rs;
    logic        ld;
    logic [15:0] lv;
    logic        st;
    logic        sp;
    logic        tk;
    logic        ci;
    logic [15:0] ec;
    logic        er;
    logic        ed;
    logic        ei;
  } vec_t;

  vec_t tbl[10];

  always #5 clock = ~clock;

  countdown_timer #(.WIDTH(16), .PRESCALE(1)) dut1 (
    .clock(clock), .reset(reset), .load(load),
    .loadValue(loadValue), .start(start),
    .stop(stop), .autoReload(autoReload),
    .tick(tick), .clearIrq(clearIrq),
    .count(c1), .running(r1), .done(d1),
    .irq(i1)
  );

  countdown_timer #(.WIDTH(16), .PRESCALE(4)) dut4 (
    .clock(clock), .reset(reset), .load(load),
    .loadValue(loadValue), .start(start),
    .stop(stop), .autoReload(autoReload),
    .tick(tick), .clearIrq(clearIrq),
    .count(c4), .running(r4), .done(d4),
    .irq(i4)
  );

  task automatic cyc(
    input logic        rs,
    input logic        ld,
    input logic [15:0] lv,
    input logic        st,
    input logic        sp,
    input logic        tk,
    input logic        ci,
    input logic [15:0] ec,
    input logic        er,
    input logic        ed,
    input logic        ei,
    input bit          sel,
    input string       nm
  );
    exp_t e;
    exp_t a;
    @(negedge clock);
    reset      = rs;
    load       = ld;
    loadValue  = lv;
    start      = st;
    stop       = sp;
    tick       = tk;
    clearIrq   = ci;
    autoReload = arl;
    e.c = ec; e.r = er; e.d = ed; e.i = ei;
    q.push_back(e);
    @(posedge clock);
    #1;
    if (sel) begin
      a.c = c4; a.r = r4; a.d = d4; a.i = i4;
    end else begin
      a.c = c1; a.r = r1; a.d = d1; a.i = i1;
    end
    e = q.pop_front();
    total++;
    if (a == e) begin
      passed++;
    end else begin
      $display(
        "FAIL %s: got c=%h r=%b d=%b i=%b want c=%h r=%b d=%b i=%b",
        nm, a.c, a.r, a.d, a.i,
        e.c, e.r, e.d, e.i);
    end
  endtask

  task automatic rst(input bit sel);
    cyc(1,0,0,0,0,0,0, 16'd0,0,0,0, sel, "reset");
  endtask

  initial begin
    tbl[0] = '{0,1,16'd5,0,0,0,0, 16'd5,0,0,0};
    tbl[1] = '{0,0,16'd0,1,0,1,0, 16'd5,1,0,0};
    tbl[2] = '{0,0,16'd0,0,0,1,0, 16'd4,1,0,0};
    tbl[3] = '{0,0,16'd0,0,0,1,0, 16'd3,1,0,0};
    tbl[4] = '{0,0,16'd0,0,0,1,0, 16'd2,1,0,0};
    tbl[5] = '{0,0,16'd0,0,0,1,0, 16'd1,1,0,0};
    tbl[6] = '{0,0,16'd0,0,0,1,0, 16'd0,0,1,1};
    tbl[7] = '{0,0,16'd0,0,0,1,0, 16'd0,0,0,1};
    tbl[8] = '{0,0,16'd0,1,0,1,0, 16'd0,0,0,1};
    tbl[9] = '{0,0,16'd0,0,0,0,1, 16'd0,0,0,0};

    // one-shot and start-at-zero
    rst(0);
    for (int k = 0; k < 10; k++) begin
      cyc(tbl[k].rs, tbl[k].ld, tbl[k].lv,
          tbl[k].st, tbl[k].sp, tbl[k].tk,
          tbl[k].ci, tbl[k].ec, tbl[k].er,
          tbl[k].ed, tbl[k].ei, 0, "oneshot");
    end

    // prescale 4 with tick toggling
    rst(1);
    cyc(0,1,16'd2,0,0,0,0, 16'd2,0,0,0, 1, "p_load");
    cyc(0,0,0,1,0,0,0, 16'd2,1,0,0, 1, "p_start");
    for (int k = 0; k < 16; k++) begin
      logic [15:0] ec;
      ec = (k < 6) ? 16'd2 :
           (k < 14) ? 16'd1 : 16'd0;
      cyc(0,0,0,0,0, logic'(k % 2 == 0), 0,
          ec, logic'(k < 14), logic'(k == 14),
          logic'(k >= 14), 1, "prescale");
    end

    // load while running clears prescaler
    rst(1);
    cyc(0,1,16'd2,0,0,0,0, 16'd2,0,0,0, 1, "l_load");
    cyc(0,0,0,1,0,0,0, 16'd2,1,0,0, 1, "l_start");
    for (int k = 0; k < 3; k++)
      cyc(0,0,0,0,0,1,0, 16'd2,1,0,0, 1, "l_pre");
    cyc(0,1,16'd5,0,0,1,0, 16'd5,1,0,0, 1, "l_reload");
    for (int k = 0; k < 3; k++)
      cyc(0,0,0,0,0,1,0, 16'd5,1,0,0, 1, "l_hold");
    cyc(0,0,0,0,0,1,0, 16'd4,1,0,0, 1, "l_dec");

    // auto-reload, irq sticky, collisions
    arl = 1'b1;
    rst(0);
    cyc(0,1,16'd3,0,0,0,0, 16'd3,0,0,0, 0, "a_load");
    cyc(0,0,0,1,0,0,0, 16'd3,1,0,0, 0, "a_start");
    cyc(0,0,0,0,0,1,0, 16'd2,1,0,0, 0, "a_t1");
    cyc(0,0,0,0,0,1,0, 16'd1,1,0,0, 0, "a_t2");
    cyc(0,0,0,0,0,1,0, 16'd3,1,1,1, 0, "a_exp1");
    cyc(0,0,0,0,0,1,0, 16'd2,1,0,1, 0, "a_t4");
    cyc(0,0,0,0,0,1,0, 16'd1,1,0,1, 0, "a_t5");
    cyc(0,0,0,0,0,1,0, 16'd3,1,1,1, 0, "a_exp2");
    cyc(0,0,0,0,0,1,1, 16'd2,1,0,0, 0, "a_clr");
    cyc(0,0,0,0,0,1,0, 16'd1,1,0,0, 0, "a_t8");
    cyc(0,0,0,0,0,1,0, 16'd3,1,1,1, 0, "a_exp3");
    cyc(0,0,0,0,0,1,0, 16'd2,1,0,1, 0, "a_t10");
    cyc(0,0,0,0,0,1,0, 16'd1,1,0,1, 0, "a_t11");
    cyc(0,0,0,0,0,1,1, 16'd3,1,1,1, 0, "clr_vs_exp");
    cyc(0,0,0,0,0,1,0, 16'd2,1,0,1, 0, "a_t13");
    cyc(0,0,0,0,0,1,0, 16'd1,1,0,1, 0, "a_t14");
    cyc(0,1,16'd9,0,0,1,0, 16'd9,1,0,1, 0, "load_vs_exp");
    arl = 1'b0;
    cyc(0,0,0,0,0,1,0, 16'd8,1,0,1, 0, "a_t16");

    // stop holds, start resumes
    cyc(0,0,0,0,0,1,0, 16'd7,1,0,1, 0, "s_t");
    cyc(0,0,0,0,1,1,0, 16'd7,0,0,1, 0, "s_stop");
    for (int k = 0; k < 10; k++)
      cyc(0,0,0,0,0,1,0, 16'd7,0,0,1, 0, "s_hold");
    cyc(0,0,0,1,0,1,0, 16'd7,1,0,1, 0, "s_start");
    cyc(0,0,0,0,0,1,0, 16'd6,1,0,1, 0, "s_t2");

    // reset mid-count, then start at zero
    cyc(0,1,16'h1234,0,0,1,0,
        16'h1234,1,0,1, 0, "m_load");
    cyc(1,0,0,0,0,1,0, 16'd0,0,0,0, 0, "m_reset");
    cyc(0,0,0,1,0,1,0, 16'd0,0,0,0, 0, "m_start0");
    cyc(0,0,0,0,0,1,0, 16'd0,0,0,0, 0, "m_idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
